// File: rtl/cpu_memory_access_pkg.sv
// Shared constants, state encoding and lane helpers for the memory-access stage.
package cpu_memory_access_pkg;

  localparam int TAG_SIZE = 4;

  localparam logic [2:0] MEM_WIDTH_B = 3'd1;
  localparam logic [2:0] MEM_WIDTH_H = 3'd2;
  localparam logic [2:0] MEM_WIDTH_W = 3'd4;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ1 = 2'd1,
    MEM_REQ2 = 2'd2,
    MEM_DONE = 2'd3
  } mem_state_t;

  // Any width code other than byte/half is handled as a full word.
  function automatic logic [2:0] norm_width(input logic [2:0] width);
    case (width)
      MEM_WIDTH_B: return MEM_WIDTH_B;
      MEM_WIDTH_H: return MEM_WIDTH_H;
      default:     return MEM_WIDTH_W;
    endcase
  endfunction

  // Byte enables across two consecutive words; bits [7:4] belong to the next word.
  function automatic logic [7:0] lane_mask(input logic [2:0] width, input logic [1:0] offset);
    logic [7:0] base;
    case (width)
      MEM_WIDTH_B: base = 8'h01;
      MEM_WIDTH_H: base = 8'h03;
      default:     base = 8'h0F;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/cpu_memory_access_load_align.sv
// Load data alignment: merges a split access, shifts the addressed bytes down,
// masks to the access width and sign- or zero-extends.
module cpu_load_align
  import cpu_memory_access_pkg::*;
(
  input  logic        i_split,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_width,
  input  logic        i_signed,
  input  logic [31:0] i_rdata_first,
  input  logic [31:0] i_rdata_now,
  output logic [31:0] o_data
);

  logic [63:0] w_merged;
  logic [31:0] w_shifted;

  always_comb begin
    w_merged  = i_split ? {i_rdata_now, i_rdata_first} : {32'b0, i_rdata_now};
    w_shifted = 32'(w_merged >> {i_offset, 3'b000});
    case (i_width)
      MEM_WIDTH_B: o_data = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
      MEM_WIDTH_H: o_data = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
      default:     o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/cpu_memory_access.sv
// Memory-access pipeline stage: bus loads/stores, ALU passthrough, optional timeout.
// Build option CPU_MEM_MISALIGNED_EN splits word-crossing accesses instead of faulting them.
//   state    | meaning
//   MEM_IDLE | waiting for new work; ALU results retire here in one edge
//   MEM_REQ1 | bus request for the first (or only) word
//   MEM_REQ2 | bus request for the following word of a split access
//   MEM_DONE | result/fault handed to writeback once i_stall is low
module cpu_memory_access
  import cpu_memory_access_pkg::*;
#(
  parameter int TAG_W   = TAG_SIZE,
  parameter int TIMEOUT = 0
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic [TAG_W-1:0] i_tag,
  input  logic [4:0]       i_inst_rd,
  input  logic [31:0]      i_rd,
  input  logic             i_mem_read,
  input  logic             i_mem_write,
  input  logic [2:0]       i_mem_width,
  input  logic             i_mem_signed,
  input  logic [31:0]      i_mem_address,
  output logic             o_bus_request,
  output logic             o_bus_rw,
  output logic [31:0]      o_bus_address,
  output logic [31:0]      o_bus_wdata,
  output logic [3:0]       o_bus_be,
  input  logic             i_bus_ready,
  input  logic [31:0]      i_bus_rdata,
  output logic [TAG_W-1:0] o_tag,
  output logic [4:0]       o_inst_rd,
  output logic [31:0]      o_rd,
  output logic             o_fault,
  output logic             o_stall
);

  localparam int TMR_W = 16;
  localparam logic [TMR_W-1:0] TMR_LOAD = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

  mem_state_t r_state, w_state_next;

  logic [TAG_W-1:0] r_tag_in;
  logic [4:0]       r_inst_rd;
  logic [31:0]      r_rd_in;
  logic [31:0]      r_addr;
  logic [31:0]      r_rdata_first;
  logic [31:0]      r_result;
  logic [2:0]       r_width;
  logic             r_write;
  logic             r_signed;
  logic             r_fault;
  logic [TMR_W-1:0] r_timer;

  logic        w_accept;
  logic        w_in_mem;
  logic        w_misalign_fault;
  logic        w_in_req;
  logic        w_timeout;
  logic        w_split;
  logic [7:0]  w_lanes;
  logic [63:0] w_wide_wdata;
  logic [31:0] w_word_addr;
  logic [31:0] w_load_data;

  assign w_accept = !i_stall && (i_tag != o_tag) && (r_state == MEM_IDLE);
  assign w_in_mem = i_mem_read | i_mem_write;
  assign o_stall  = (i_tag != o_tag) && (r_state != MEM_IDLE);

`ifdef CPU_MEM_MISALIGNED_EN
  assign w_misalign_fault = 1'b0;
`else
  logic [7:0] w_in_lanes;
  assign w_in_lanes       = lane_mask(norm_width(i_mem_width), i_mem_address[1:0]);
  assign w_misalign_fault = |w_in_lanes[7:4];
`endif

  assign w_lanes      = lane_mask(r_width, r_addr[1:0]);
  assign w_split      = |w_lanes[7:4];
  assign w_wide_wdata = {32'b0, r_rd_in} << {r_addr[1:0], 3'b000};
  assign w_word_addr  = {r_addr[31:2], 2'b00};
  assign w_in_req     = (r_state == MEM_REQ1) || (r_state == MEM_REQ2);
  assign w_timeout    = (TIMEOUT != 0) && w_in_req && !i_bus_ready && (r_timer == '0);

  cpu_load_align u_load_align (
    .i_split       (w_split),
    .i_offset      (r_addr[1:0]),
    .i_width       (r_width),
    .i_signed      (r_signed),
    .i_rdata_first (r_rdata_first),
    .i_rdata_now   (i_bus_rdata),
    .o_data        (w_load_data)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= MEM_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MEM_IDLE: if (w_accept && w_in_mem) w_state_next = w_misalign_fault ? MEM_DONE : MEM_REQ1;
      MEM_REQ1: begin
        if (i_bus_ready)    w_state_next = w_split ? MEM_REQ2 : MEM_DONE;
        else if (w_timeout) w_state_next = MEM_DONE;
      end
      MEM_REQ2: if (i_bus_ready || w_timeout) w_state_next = MEM_DONE;
      MEM_DONE: if (!i_stall) w_state_next = MEM_IDLE;
      default:  w_state_next = MEM_IDLE;
    endcase
  end

  always_comb begin
    o_bus_request = 1'b0;
    o_bus_rw      = 1'b0;
    o_bus_address = '0;
    o_bus_wdata   = '0;
    o_bus_be      = '0;
    if (w_in_req) begin
      o_bus_request = 1'b1;
      o_bus_rw      = r_write;
      if (r_state == MEM_REQ2) begin
        o_bus_address = w_word_addr + 32'd4;
        o_bus_wdata   = r_write ? w_wide_wdata[63:32] : 32'b0;
        o_bus_be      = w_lanes[7:4];
      end else begin
        o_bus_address = w_word_addr;
        o_bus_wdata   = r_write ? w_wide_wdata[31:0] : 32'b0;
        o_bus_be      = w_lanes[3:0];
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tag_in      <= '0;
      r_inst_rd     <= '0;
      r_rd_in       <= '0;
      r_addr        <= '0;
      r_rdata_first <= '0;
      r_result      <= '0;
      r_width       <= '0;
      r_write       <= 1'b0;
      r_signed      <= 1'b0;
      r_fault       <= 1'b0;
      r_timer       <= '0;
      o_tag         <= '0;
      o_inst_rd     <= '0;
      o_rd          <= '0;
      o_fault       <= 1'b0;
    end else begin
      case (r_state)
        MEM_IDLE: begin
          if (w_accept) begin
            r_tag_in  <= i_tag;
            r_inst_rd <= i_inst_rd;
            r_rd_in   <= i_rd;
            r_addr    <= i_mem_address;
            r_write   <= i_mem_write;
            r_signed  <= i_mem_signed;
            r_width   <= norm_width(i_mem_width);
            r_timer   <= TMR_LOAD;
            r_result  <= '0;
            r_fault   <= w_misalign_fault;
            if (!w_in_mem) begin
              o_rd      <= i_rd;
              o_inst_rd <= i_inst_rd;
              o_fault   <= 1'b0;
              o_tag     <= i_tag;
            end
          end
        end
        MEM_REQ1, MEM_REQ2: begin
          if (i_bus_ready) begin
            // First half of a split access: keep its data and restart the timer for the second.
            if ((r_state == MEM_REQ1) && w_split) begin
              r_rdata_first <= i_bus_rdata;
              r_timer       <= TMR_LOAD;
            end else begin
              r_result <= r_write ? r_rd_in : w_load_data;
              r_fault  <= 1'b0;
            end
          end else if (w_timeout) begin
            r_result <= '0;
            r_fault  <= 1'b1;
          end else if (r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
          end
        end
        MEM_DONE: begin
          if (!i_stall) begin
            o_rd      <= r_result;
            o_fault   <= r_fault;
            o_inst_rd <= r_inst_rd;
            o_tag     <= r_tag_in;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
